// File: rtl/spi_mailbox_master_pkg.sv
// rtl/spi_mailbox_master_pkg.sv - shared widths, field positions and FSM states for the SPI mailbox master
package spi_mailbox_master_pkg;

    localparam int ENTRY_W = 41;
    localparam int RW_BIT  = 40;
    localparam int CMD_HI  = 39;
    localparam int CMD_LO  = 32;
    localparam int DATA_W  = 32;
    localparam int FRAME_W = 40;

    typedef enum logic [2:0] {
        IDLE,
        POLL,
        LOAD,
        SHIFT,
        FINISH,
        GAP
    } state_e;

endpackage

// File: rtl/spi_mailbox_master_if.sv
// rtl/spi_mailbox_master_if.sv - mailbox B-port handshake between the SPI master and the mailbox
interface spi_mailbox_master_if;

    logic                                         mb_en;
    logic [4:0]                                   mb_addr;
    logic [spi_mailbox_master_pkg::ENTRY_W-1:0]   mb_rdata;
    logic                                         mb_dvalid;
    logic                                         mb_stop;
    logic                                         mb_done;
    logic [spi_mailbox_master_pkg::ENTRY_W-1:0]   mb_wdata;

    modport master (
        output mb_en,
        output mb_addr,
        output mb_done,
        output mb_wdata,
        input  mb_rdata,
        input  mb_dvalid,
        input  mb_stop
    );

    modport slave (
        input  mb_en,
        input  mb_addr,
        input  mb_done,
        input  mb_wdata,
        output mb_rdata,
        output mb_dvalid,
        output mb_stop
    );

endinterface

// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - mode-0 SPI serialiser: prescaler, SCLK, 40-bit shift register, MISO capture
module spi_shift_engine
    import spi_mailbox_master_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [FRAME_W-1:0] frame,
    output logic               done,
    output logic [DATA_W-1:0]  rx_data,
    output logic               spi_sclk,
    output logic               spi_cs_n,
    output logic               spi_mosi,
    input  logic               spi_miso
);

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int EDGES  = 2 * FRAME_W;
    localparam int EDGE_W = $clog2(EDGES + 1);

    logic               active_q, active_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [EDGE_W-1:0]  edge_q, edge_d;
    logic               sclk_q, sclk_d;
    logic               cs_n_q, cs_n_d;
    logic [FRAME_W-1:0] sr_q, sr_d;
    logic [DATA_W-1:0]  rx_q, rx_d;
    logic               done_q, done_d;
    logic               tick;

    assign tick = (div_q == DIV_W'(CLK_DIV - 1));

    // After the 80th edge one extra half-period elapses with SCLK low before CS is released.
    always_comb begin
        active_d = active_q;
        div_d    = div_q;
        edge_d   = edge_q;
        sclk_d   = sclk_q;
        cs_n_d   = cs_n_q;
        sr_d     = sr_q;
        rx_d     = rx_q;
        done_d   = 1'b0;
        if (start) begin
            active_d = 1'b1;
            div_d    = '0;
            edge_d   = '0;
            sclk_d   = 1'b0;
            cs_n_d   = 1'b0;
            sr_d     = frame;
            rx_d     = '0;
        end else if (active_q) begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) begin
                if (edge_q == EDGE_W'(EDGES)) begin
                    active_d = 1'b0;
                    cs_n_d   = 1'b1;
                    done_d   = 1'b1;
                end else begin
                    edge_d = edge_q + 1'b1;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        rx_d = {rx_q[DATA_W-2:0], spi_miso};
                    end else begin
                        sr_d = {sr_q[FRAME_W-2:0], 1'b0};
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            div_q    <= '0;
            edge_q   <= '0;
            sclk_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            sr_q     <= '0;
            rx_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            div_q    <= div_d;
            edge_q   <= edge_d;
            sclk_q   <= sclk_d;
            cs_n_q   <= cs_n_d;
            sr_q     <= sr_d;
            rx_q     <= rx_d;
            done_q   <= done_d;
        end
    end

    assign done     = done_q;
    assign rx_data  = rx_q;
    assign spi_sclk = sclk_q;
    assign spi_cs_n = cs_n_q;
    assign spi_mosi = sr_q[FRAME_W-1];

endmodule

// File: rtl/spi_mailbox_master.sv
// rtl/spi_mailbox_master.sv - polls mailbox slots, sends each entry as a 40-bit SPI frame, writes back results
module spi_mailbox_master
    import spi_mailbox_master_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int NUM_SLOTS = 16,
    parameter int POLL_WAIT = 3,
    parameter int CS_GAP    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    spi_mailbox_master_if.master  mb,
    output logic                  spi_sclk,
    output logic                  spi_cs_n,
    output logic                  spi_mosi,
    input  logic                  spi_miso,
    output logic                  busy,
    output logic [15:0]           frame_cnt
);

    localparam int PTR_W   = $clog2(NUM_SLOTS);
    localparam int WAIT_W  = $clog2(POLL_WAIT + 1);
    localparam int GAP_CYC = CS_GAP * CLK_DIV;
    localparam int GAP_W   = $clog2(GAP_CYC + 1);

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               skip_q, skip_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [ENTRY_W-1:0] entry_q, entry_d;
    logic               mb_en_q, mb_en_d;
    logic [4:0]         mb_addr_q, mb_addr_d;
    logic               mb_done_q, mb_done_d;
    logic [ENTRY_W-1:0] mb_wdata_q, mb_wdata_d;
    logic               busy_q, busy_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;

    logic               eng_done;
    logic [DATA_W-1:0]  eng_rx;
    logic [PTR_W-1:0]   next_ptr;

    assign next_ptr = (ptr_q == PTR_W'(NUM_SLOTS - 1)) ? '0 : ptr_q + 1'b1;

    spi_shift_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_engine (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (state_q == LOAD),
        .frame    ({entry_q[RW_BIT], entry_q[CMD_HI-1:CMD_LO], entry_q[DATA_W-1:0]}),
        .done     (eng_done),
        .rx_data  (eng_rx),
        .spi_sclk (spi_sclk),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        wait_d      = wait_q;
        skip_d      = skip_q;
        gap_d       = gap_q;
        entry_d     = entry_q;
        mb_en_d     = mb_en_q;
        mb_addr_d   = mb_addr_q;
        mb_done_d   = 1'b0;
        mb_wdata_d  = mb_wdata_q;
        busy_d      = busy_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            IDLE: begin
                mb_en_d = 1'b0;
                if (enable) begin
                    state_d   = POLL;
                    mb_en_d   = 1'b1;
                    mb_addr_d = 5'(ptr_q);
                    wait_d    = '0;
                    skip_d    = 1'b0;
                end
            end
            POLL: begin
                // skip_q marks the one-cycle enable-low bubble between two slot probes
                if (skip_q) begin
                    skip_d = 1'b0;
                    if (enable) begin
                        mb_en_d   = 1'b1;
                        mb_addr_d = 5'(ptr_q);
                        wait_d    = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (mb.mb_dvalid) begin
                    entry_d = mb.mb_rdata;
                    mb_en_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end else if (mb.mb_stop || wait_q == WAIT_W'(POLL_WAIT - 1)) begin
                    mb_en_d = 1'b0;
                    skip_d  = 1'b1;
                    ptr_d   = next_ptr;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            LOAD: begin
                state_d = SHIFT;
            end
            SHIFT: begin
                if (eng_done) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                mb_done_d   = 1'b1;
                mb_en_d     = 1'b1;
                mb_wdata_d  = entry_q[RW_BIT] ? {1'b1, entry_q[CMD_HI:CMD_LO], eng_rx} : entry_q;
                frame_cnt_d = frame_cnt_q + 16'd1;
                ptr_d       = next_ptr;
                gap_d       = '0;
                state_d     = GAP;
            end
            GAP: begin
                mb_en_d = 1'b0;
                if (gap_q == GAP_W'(GAP_CYC - 1)) begin
                    busy_d = 1'b0;
                    if (enable) begin
                        state_d   = POLL;
                        mb_en_d   = 1'b1;
                        mb_addr_d = 5'(ptr_q);
                        wait_d    = '0;
                        skip_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            wait_q      <= '0;
            skip_q      <= 1'b0;
            gap_q       <= '0;
            entry_q     <= '0;
            mb_en_q     <= 1'b0;
            mb_addr_q   <= '0;
            mb_done_q   <= 1'b0;
            mb_wdata_q  <= '0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            wait_q      <= wait_d;
            skip_q      <= skip_d;
            gap_q       <= gap_d;
            entry_q     <= entry_d;
            mb_en_q     <= mb_en_d;
            mb_addr_q   <= mb_addr_d;
            mb_done_q   <= mb_done_d;
            mb_wdata_q  <= mb_wdata_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign mb.mb_en    = mb_en_q;
    assign mb.mb_addr  = mb_addr_q;
    assign mb.mb_done  = mb_done_q;
    assign mb.mb_wdata = mb_wdata_q;
    assign busy        = busy_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_spi_mailbox_master.sv
// tb/tb_spi_mailbox_master.sv - scoreboard bench for spi_mailbox_master with mailbox and SPI slave models
module tb_spi_mailbox_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        spi_sclk, spi_cs_n, spi_mosi, spi_miso, busy;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    spi_mailbox_master_if mbif ();

    spi_mailbox_master dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .mb        (mbif),
        .spi_sclk  (spi_sclk),
        .spi_cs_n  (spi_cs_n),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    // Mailbox model: valid slots ack, silent slots never answer, all others report stop.
    logic [15:0] slot_valid = '0;
    logic [15:0] slot_silent = '0;
    logic [40:0] slot_data [16];
    logic [3:0]  a;

    assign a              = mbif.mb_addr[3:0];
    assign mbif.mb_rdata  = slot_data[a];
    assign mbif.mb_dvalid = mbif.mb_en && !mbif.mb_done && slot_valid[a];
    assign mbif.mb_stop   = mbif.mb_en && !mbif.mb_done && !slot_valid[a] && !slot_silent[a];

    // SPI slave model, mode 0.
    int          rise_cnt = 0;
    logic [39:0] rx_mosi = '0;
    logic [39:0] tx_word = '0;
    logic [5:0]  tx_idx;

    always @(posedge spi_sclk or negedge spi_cs_n) begin
        if (spi_sclk) begin
            rx_mosi  <= {rx_mosi[38:0], spi_mosi};
            rise_cnt <= rise_cnt + 1;
        end else begin
            rx_mosi  <= '0;
            rise_cnt <= 0;
        end
    end

    assign tx_idx   = 6'(39 - rise_cnt);
    assign spi_miso = (rise_cnt < 40) ? tx_word[tx_idx] : 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [40:0] wdata;
        logic [4:0]  addr;
        logic [39:0] mosi;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   poll_log[$];

    int   cyc = 0;
    int   cap_cyc = 0;
    int   cs_fall_cyc = 0;
    int   cs_len = 0;
    int   first_rise_off = 0;
    logic rise_pending = 1'b0;
    logic busy_p = 1'b0, cs_p = 1'b1, sclk_p = 1'b0, done_p = 1'b0, en_p = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        cyc <= cyc + 1;
        if (busy && !busy_p) cap_cyc <= cyc;
        if (!spi_cs_n && cs_p) begin
            cs_fall_cyc  <= cyc;
            rise_pending <= 1'b1;
        end
        if (spi_cs_n && !cs_p) cs_len <= cyc - cs_fall_cyc;
        if (spi_sclk && !sclk_p && rise_pending) begin
            first_rise_off <= cyc - cs_fall_cyc;
            rise_pending   <= 1'b0;
        end
        if (mbif.mb_en && !en_p && !mbif.mb_done) poll_log.push_back(int'(mbif.mb_addr));
        if (rst_n && mbif.mb_done) begin
            check("done_width", 64'(done_p), 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("wb_wdata", 64'(mbif.mb_wdata), 64'(e.wdata));
                check("wb_addr", 64'(mbif.mb_addr), 64'(e.addr));
                check("wb_frame_cnt", 64'(frame_cnt), 64'(e.cnt));
                check("mosi_frame", 64'(rx_mosi), 64'(e.mosi));
                check("sclk_periods", 64'(rise_cnt), 64'd40);
                check("cs_low_cycles", 64'(cs_len), 64'd324);
                check("first_sclk_offset", 64'(first_rise_off), 64'd4);
                check("capture_to_done", 64'(cyc - cap_cyc), 64'd327);
            end
        end
        busy_p <= busy;
        cs_p   <= spi_cs_n;
        sclk_p <= spi_sclk;
        done_p <= mbif.mb_done;
        en_p   <= mbif.mb_en;
    end

    task automatic wait_frames(input int n, input string name);
        int k = 0;
        while (frame_cnt != 16'(n) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check(name, 64'(frame_cnt), 64'(n));
    endtask

    initial begin
        int k;
        int li;
        int bad;
        int n;
        for (int i = 0; i < 16; i++) slot_data[i] = '0;
        repeat (3) @(negedge clk);

        check("rst_mb_en", 64'(mbif.mb_en), 64'd0);
        check("rst_mb_addr", 64'(mbif.mb_addr), 64'd0);
        check("rst_mb_done", 64'(mbif.mb_done), 64'd0);
        check("rst_mb_wdata", 64'(mbif.mb_wdata), 64'd0);
        check("rst_sclk", 64'(spi_sclk), 64'd0);
        check("rst_cs_n", 64'(spi_cs_n), 64'd1);
        check("rst_mosi", 64'(spi_mosi), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);

        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_mb_en", 64'(mbif.mb_en), 64'd0);

        // Slots 0-14 report stop, slot 15 holds a write entry
        li = poll_log.size();
        slot_data[15]  = 41'h0F00F0F0F0F;
        slot_valid[15] = 1'b1;
        exp_q.push_back('{41'h0F00F0F0F0F, 5'd15, 40'h700F0F0F0F, 16'd1});
        enable = 1'b1;
        k = 0;
        while (!busy && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("t3_capture", 64'(busy), 64'd1);
        slot_valid[15] = 1'b0;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (poll_log.size() <= li + i) bad++;
            else if (poll_log[li + i] != i) bad++;
        end
        check("t3_poll_sequence", 64'(bad), 64'd0);
        wait_frames(1, "t3_frames");

        // Write entry in slot 0, also proves the pointer wrapped
        li = poll_log.size();
        slot_data[0]  = 41'h0A512345678;
        slot_valid[0] = 1'b1;
        exp_q.push_back('{41'h0A512345678, 5'd0, 40'h2512345678, 16'd2});
        k = 0;
        while (poll_log.size() <= li && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("t3_wrap_addr", (poll_log.size() > li) ? 64'(poll_log[li]) : 64'hFFFF, 64'd0);
        wait_frames(2, "t1_frames");
        slot_valid[0] = 1'b0;

        // Read entry in slot 5, slave returns DEADBEEF in the data phase
        slot_data[5]  = 41'h10300000000;
        slot_valid[5] = 1'b1;
        tx_word       = 40'h00DEADBEEF;
        exp_q.push_back('{41'h103DEADBEEF, 5'd5, 40'h8300000000, 16'd3});
        wait_frames(3, "t2_frames");
        slot_valid[5] = 1'b0;
        tx_word       = '0;

        // Slot 3 never answers
        slot_silent[3] = 1'b1;
        k = 0;
        while (!(mbif.mb_en && mbif.mb_addr == 5'd3) && k < 200) begin
            @(negedge clk);
            k++;
        end
        n   = 0;
        bad = 0;
        while (mbif.mb_en && mbif.mb_addr == 5'd3 && n < 10) begin
            if (!spi_cs_n) bad++;
            n++;
            @(negedge clk);
        end
        check("t4_wait_cycles", 64'(n), 64'd3);
        check("t4_bubble_en", 64'(mbif.mb_en), 64'd0);
        check("t4_cs_quiet", 64'(bad), 64'd0);
        @(negedge clk);
        check("t4_next_addr", 64'(mbif.mb_addr), 64'd4);
        check("t4_next_en", 64'(mbif.mb_en), 64'd1);
        slot_silent[3] = 1'b0;

        // enable falls at SCLK 10; the frame must still complete
        slot_data[7]  = 41'h03CCAFEF00D;
        slot_valid[7] = 1'b1;
        exp_q.push_back('{41'h03CCAFEF00D, 5'd7, 40'h3CCAFEF00D, 16'd4});
        k = 0;
        while (!(!spi_cs_n && rise_cnt == 10) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("t5_reached_sclk10", 64'(rise_cnt), 64'd10);
        enable = 1'b0;
        wait_frames(4, "t5_frames");
        slot_valid[7] = 1'b0;
        k = 0;
        while (busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("t5_busy_clear", 64'(busy), 64'd0);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (mbif.mb_en) bad++;
        end
        check("t5_idle_no_poll", 64'(bad), 64'd0);

        // Reset asserted at SCLK 20 of a frame
        slot_data[9]  = 41'h05500000055;
        slot_valid[9] = 1'b1;
        enable = 1'b1;
        k = 0;
        while (!(!spi_cs_n && rise_cnt == 20) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("t6_reached_sclk20", 64'(rise_cnt), 64'd20);
        rst_n = 1'b0;
        #1;
        check("t6_cs_n_async", 64'(spi_cs_n), 64'd1);
        check("t6_sclk_async", 64'(spi_sclk), 64'd0);
        check("t6_busy_async", 64'(busy), 64'd0);
        check("t6_frame_cnt_async", 64'(frame_cnt), 64'd0);
        slot_valid[9] = 1'b0;
        repeat (3) @(negedge clk);
        li = poll_log.size();
        rst_n = 1'b1;
        k = 0;
        while (poll_log.size() <= li && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("t6_restart_addr", (poll_log.size() > li) ? 64'(poll_log[li]) : 64'hFFFF, 64'd0);
        repeat (400) @(negedge clk);
        check("t6_no_frames", 64'(frame_cnt), 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
